// File: rtl/pll_dyn_cfg.sv
// Dynamic PLL reconfiguration sequencer: gates output clocks, reprograms the dividers,
// pulses PLL reset and waits for a stable synchronised lock with bounded retries.
module pll_dyn_cfg #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned DEF_IDIV     = 1,
    parameter int unsigned DEF_FBDIV    = 1,
    parameter int unsigned DEF_MDIV     = 37,
    parameter int unsigned DEF_ODIV     = 5
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [5:0]          cfg_idiv_i,
    input  logic [5:0]          cfg_fbdiv_i,
    input  logic [6:0]          cfg_mdiv_i,
    input  logic [7*NUM_CH-1:0] cfg_odiv_i,
    input  logic [NUM_CH-1:0]   cfg_en_i,
    input  logic                pll_lock_i,
    output logic                pll_reset_o,
    output logic [5:0]          pll_idsel_o,
    output logic [5:0]          pll_fbdsel_o,
    output logic [6:0]          pll_mdsel_o,
    output logic [7*NUM_CH-1:0] pll_odsel_o,
    output logic [NUM_CH-1:0]   pll_enclk_o,
    output logic                busy_o,
    output logic                locked_o,
    output logic                done_o,
    output logic                err_o,
    output logic                lock_lost_o
);

    localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
    localparam int unsigned StbW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned ToW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RtW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [7*NUM_CH-1:0] DefOdsel = {NUM_CH{7'(DEF_ODIV)}};

    typedef enum logic [2:0] {StIdle, StGate, StPrst, StWaitLock, StUngate, StErr} state_e;

    state_e              state_q, state_d;
    logic                lock_meta_q, lock_sync_q;
    logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [StbW-1:0]     stable_q, stable_d;
    logic [ToW-1:0]      to_q, to_d;
    logic [RtW-1:0]      retry_q, retry_d;
    logic [NUM_CH-1:0]   enclk_q, enclk_d;
    logic                locked_q, locked_d;
    logic                cfg_take, load_sel;

    logic [5:0]          idiv_q, fbdiv_q, idsel_q, fbdsel_q;
    logic [6:0]          mdiv_q, mdsel_q;
    logic [7*NUM_CH-1:0] odiv_q, odsel_q;
    logic [NUM_CH-1:0]   en_q;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        stable_d  = '0;
        to_d      = '0;
        retry_d   = retry_q;
        enclk_d   = enclk_q;
        locked_d  = locked_q;
        cfg_take  = 1'b0;
        load_sel  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // No automatic relock: a dropped lock only gates the clocks.
                if (locked_q && !lock_sync_q) begin
                    locked_d = 1'b0;
                    enclk_d  = '0;
                end
                if (cfg_valid_i) begin
                    cfg_take = 1'b1;
                    enclk_d  = '0;
                    locked_d = 1'b0;
                    state_d  = StGate;
                end
            end
            StGate: begin
                load_sel = 1'b1;
                state_d  = StPrst;
            end
            StPrst: begin
                rst_cnt_d = (rst_cnt_q == RstW'(RST_CYCLES)) ? rst_cnt_q : rst_cnt_q + 1'b1;
                if (rst_cnt_q == RstW'(RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_sync_q) begin
                    stable_d = (stable_q == StbW'(LOCK_STABLE)) ? stable_q : stable_q + 1'b1;
                end
                to_d = (to_q == ToW'(LOCK_TIMEOUT)) ? to_q : to_q + 1'b1;
                if (lock_sync_q && stable_q == StbW'(LOCK_STABLE - 1)) begin
                    enclk_d  = en_q;
                    locked_d = 1'b1;
                    state_d  = StUngate;
                end else if (to_q == ToW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_q < RtW'(MAX_RETRY)) begin
                        retry_d  = retry_q + 1'b1;
                        load_sel = 1'b1;
                        state_d  = StPrst;
                    end else begin
                        enclk_d  = '0;
                        locked_d = 1'b0;
                        state_d  = StErr;
                    end
                end
            end
            StUngate: begin
                retry_d = '0;
                state_d = StIdle;
            end
            StErr: begin
                retry_d  = '0;
                enclk_d  = '0;
                locked_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPrst;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            to_q        <= '0;
            retry_q     <= '0;
            enclk_q     <= '0;
            locked_q    <= 1'b0;
            idiv_q      <= 6'(DEF_IDIV);
            fbdiv_q     <= 6'(DEF_FBDIV);
            mdiv_q      <= 7'(DEF_MDIV);
            odiv_q      <= DefOdsel;
            en_q        <= '1;
            idsel_q     <= 6'(DEF_IDIV);
            fbdsel_q    <= 6'(DEF_FBDIV);
            mdsel_q     <= 7'(DEF_MDIV);
            odsel_q     <= DefOdsel;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= pll_lock_i;
            lock_sync_q <= lock_meta_q;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            to_q        <= to_d;
            retry_q     <= retry_d;
            enclk_q     <= enclk_d;
            locked_q    <= locked_d;
            if (cfg_take) begin
                idiv_q  <= cfg_idiv_i;
                fbdiv_q <= cfg_fbdiv_i;
                mdiv_q  <= cfg_mdiv_i;
                odiv_q  <= cfg_odiv_i;
                en_q    <= cfg_en_i;
            end
            // Dividers move only as the PLL enters reset.
            if (load_sel) begin
                idsel_q  <= idiv_q;
                fbdsel_q <= fbdiv_q;
                mdsel_q  <= mdiv_q;
                odsel_q  <= odiv_q;
            end
        end
    end

    assign cfg_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign pll_reset_o  = (state_q == StPrst);
    assign done_o       = (state_q == StUngate);
    assign err_o        = (state_q == StErr);
    assign lock_lost_o  = (state_q == StIdle) && locked_q && !lock_sync_q;
    assign locked_o     = locked_q;
    assign pll_enclk_o  = enclk_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_mdsel_o  = mdsel_q;
    assign pll_odsel_o  = odsel_q;

endmodule
